// File: rtl/mac_pkg.sv
// Shared types and constant helpers for the carry-save multiply-accumulate pipe.
package mac_pkg;

  typedef enum logic [1:0] {ACCUM, FLUSH, RESOLVE, HOLD} state_t;

  // log2 of the number of full-scale terms that fit above the product width
  function automatic int headroom(input int width, input int acc_width);
    return acc_width - 2 * width;
  endfunction

  // Baugh-Wooley constant 2^W - 2^(2W-1), folded modulo 2^acc_width (acc_width <= 64)
  function automatic logic [63:0] bw_const(input int width, input int acc_width);
    logic [63:0] c;
    c = '0;
    for (int i = 2 * width - 1; i < acc_width; i++) c[i] = 1'b1;
    c[width] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/dadda_pp_reduce.sv
// Partial-product generation (Baugh-Wooley when signed) and reduction of all
// product rows to a sum/carry pair of ACC_WIDTH bits using full_adder cells.
module dadda_pp_reduce
  import mac_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24
) (
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic [ACC_WIDTH-1:0] pp_sum,
  output logic [ACC_WIDTH-1:0] pp_carry
);
  localparam int ROWS = WIDTH + 1;
  localparam logic [63:0] BW_FULL = bw_const(WIDTH, ACC_WIDTH);
  localparam logic [ACC_WIDTH-1:0] BW = BW_FULL[ACC_WIDTH-1:0];

  logic [ROWS-1:0][ACC_WIDTH-1:0] rows;
  logic [ROWS-2:0][ACC_WIDTH-1:0] s_q;
  logic [ROWS-2:0][ACC_WIDTH-1:0] c_q;

  // Signed mode inverts the bits where exactly one index is the sign position
  always_comb begin
    rows = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++)
        rows[i][i+j] = (a[j] & b[i]) ^ (signed_mode & ((i == WIDTH - 1) != (j == WIDTH - 1)));
    rows[WIDTH] = signed_mode ? BW : '0;
  end

  assign s_q[0] = rows[0];
  assign c_q[0] = rows[1];

  for (genvar k = 1; k < ROWS - 1; k++) begin : g_stage
    logic [ACC_WIDTH-2:0] co;
    for (genvar n = 0; n < ACC_WIDTH; n++) begin : g_bit
      if (n < ACC_WIDTH - 1) begin : g_fa
        full_adder u_fa (
          .a (s_q[k-1][n]),
          .b (c_q[k-1][n]),
          .ci(rows[k+1][n]),
          .s (s_q[k][n]),
          .co(co[n])
        );
      end else begin : g_msb
        assign s_q[k][n] = s_q[k-1][n] ^ c_q[k-1][n] ^ rows[k+1][n];
      end
    end
    assign c_q[k] = {co, 1'b0};
  end

  assign pp_sum   = s_q[ROWS-2];
  assign pp_carry = c_q[ROWS-2];
endmodule

// File: rtl/full_adder.sv
// One-bit 3:2 counter cell used by the product reduction and the accumulator row.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/csa_mac_pipe.sv
// Pipelined multiply-accumulate: product rows are folded into a carry-save
// accumulator each beat; a single carry-propagate add resolves it per batch.
module csa_mac_pipe
  import mac_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  input  logic                 clear,
  input  logic                 last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 overflow
);
  localparam int HEADROOM = headroom(WIDTH, ACC_WIDTH);
  localparam int CW = HEADROOM + 1;
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] CNT_LIMIT = CNT_ONE << HEADROOM;

  state_t               state;
  logic                 mode_q, batch_new;
  logic [CW-1:0]        count;
  logic                 s1_valid, s1_first, s1_last;
  logic [ACC_WIDTH-1:0] s1_sum, s1_carry, acc_s, acc_c;
  logic [ACC_WIDTH-1:0] pp_sum, pp_carry;

  // Valid/ready: a transfer happens on a rising edge where valid && ready;
  // the producer holds its data stable until that edge.
  logic accept, first, mode_eff;
  assign accept   = in_valid & in_ready;
  assign first    = clear | batch_new;
  assign mode_eff = first ? signed_mode : mode_q;

  dadda_pp_reduce #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_reduce (
    .a          (a),
    .b          (b),
    .signed_mode(mode_eff),
    .pp_sum     (pp_sum),
    .pp_carry   (pp_carry)
  );

  // 4:2 compressor row: {s1_sum, s1_carry, base_s, base_c} -> {m_s, m_c}
  logic [ACC_WIDTH-1:0] base_s, base_c, t_s, cin, m_s;
  logic [ACC_WIDTH-2:0] t_co, m_c;
  assign base_s = s1_first ? '0 : acc_s;
  assign base_c = s1_first ? '0 : acc_c;
  assign cin    = {t_co, 1'b0};

  for (genvar n = 0; n < ACC_WIDTH; n++) begin : g_c42
    if (n < ACC_WIDTH - 1) begin : g_fa
      full_adder u_fa1 (.a(s1_sum[n]), .b(s1_carry[n]), .ci(base_s[n]), .s(t_s[n]), .co(t_co[n]));
      full_adder u_fa2 (.a(t_s[n]), .b(base_c[n]), .ci(cin[n]), .s(m_s[n]), .co(m_c[n]));
    end else begin : g_msb
      assign t_s[n] = s1_sum[n] ^ s1_carry[n] ^ base_s[n];
      assign m_s[n] = t_s[n] ^ base_c[n] ^ cin[n];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      mode_q    <= 1'b0;
      batch_new <= 1'b1;
      count     <= '0;
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_sum    <= '0;
      s1_carry  <= '0;
      acc_s     <= '0;
      acc_c     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_sum    <= pp_sum;
        s1_carry  <= pp_carry;
        s1_first  <= first;
        s1_last   <= last;
        mode_q    <= mode_eff;
        batch_new <= 1'b0;
        count     <= first ? CNT_ONE : ((count == CNT_MAX) ? count : count + CNT_ONE);
      end
      if (s1_valid) begin
        acc_s <= m_s;
        acc_c <= {m_c, 1'b0};
      end
      case (state)
        ACCUM: begin
          if (accept && last) begin
            state    <= FLUSH;
            in_ready <= 1'b0;
          end else begin
            in_ready <= 1'b1;
          end
        end
        // Wait until the last product has left stage 1
        FLUSH: if (!s1_valid) state <= RESOLVE;
        RESOLVE: begin
          result    <= acc_s + acc_c;
          overflow  <= (count > CNT_LIMIT);
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc_s     <= '0;
            acc_c     <= '0;
            count     <= '0;
            batch_new <= 1'b1;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_mac_pipe.sv
// Directed bench for csa_mac_pipe with hand-computed expected results.
module tb_csa_mac_pipe;
  localparam int WIDTH     = 8;
  localparam int ACC_WIDTH = 24;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 signed_mode;
  logic                 clear;
  logic                 last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] result;
  logic                 overflow;

  int checks = 0;
  int failures = 0;
  int stall_cycles = 0;
  logic [ACC_WIDTH-1:0] exp_q[$];
  logic                 ovf_q[$];

  csa_mac_pipe #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .signed_mode(signed_mode),
    .clear      (clear),
    .last       (last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .overflow   (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_result(input logic [ACC_WIDTH-1:0] res, input logic ovf);
    exp_q.push_back(res);
    ovf_q.push_back(ovf);
  endtask

  task automatic drive_beat(input int av, input int bv, input logic sm,
                            input logic clr, input logic lst);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
      stall_cycles++;
    end
    check("beat_ready", in_ready, 1'b1);
    a           = av[WIDTH-1:0];
    b           = bv[WIDTH-1:0];
    signed_mode = sm;
    clear       = clr;
    last        = lst;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    last     = 1'b0;
  endtask

  task automatic get_result(input string tag, input int hold);
    int n;
    logic [ACC_WIDTH-1:0] er;
    logic eo;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, out_valid, 1'b1);
    er = exp_q.pop_front();
    eo = ovf_q.pop_front();
    check({tag, "_result"}, result, er);
    check({tag, "_ovf"}, overflow, eo);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_result"}, result, er);
      check({tag, "_hold_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_ready_after"}, in_ready, 1'b1);
    check({tag, "_valid_after"}, out_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    signed_mode = 1'b0; clear = 1'b0; last = 1'b0; out_ready = 1'b0;

    // reset state
    #2;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, '0);
    check("rst_overflow", overflow, 1'b0);
    #10 rst_n = 1'b1;
    #1 check("rst_release_ready", in_ready, 1'b0);
    @(negedge clk);
    check("ready_after_release", in_ready, 1'b1);

    // unsigned single beat with latency
    expect_result(24'h00FE01, 1'b0);
    drive_beat(255, 255, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lat_idle", out_valid, 1'b0);
    end
    @(negedge clk);
    check("lat_valid", out_valid, 1'b1);
    get_result("u255", 0);

    // signed batch; later signed_mode values are ignored
    expect_result(24'h003F72, 1'b0);
    drive_beat(-128, -128, 1'b1, 1'b1, 1'b0);
    drive_beat(-1, 127, 1'b0, 1'b0, 1'b0);
    drive_beat(5, -3, 1'b0, 1'b0, 1'b1);
    get_result("signed3", 0);

    // signed single-term batch, sign extension
    expect_result(24'hFFFFFA, 1'b0);
    drive_beat(-2, 3, 1'b1, 1'b1, 1'b1);
    get_result("signed1", 0);

    // back-to-back beats, then backpressure
    expect_result(24'd10, 1'b0);
    drive_beat(1, 1, 1'b0, 1'b1, 1'b0);
    stall_cycles = 0;
    drive_beat(2, 1, 1'b0, 1'b0, 1'b0);
    drive_beat(3, 1, 1'b0, 1'b0, 1'b0);
    drive_beat(4, 1, 1'b0, 1'b0, 1'b1);
    check("b2b_stalls", stall_cycles, 0);
    get_result("b2b", 5);
    expect_result(24'd6, 1'b0);
    drive_beat(2, 3, 1'b0, 1'b0, 1'b1);
    get_result("after_bp", 0);

    // clear mid-batch restarts and re-latches signed mode
    expect_result(24'hFFFFEF, 1'b0);
    drive_beat(10, 10, 1'b0, 1'b1, 1'b0);
    drive_beat(20, 20, 1'b0, 1'b0, 1'b0);
    drive_beat(-3, 4, 1'b1, 1'b1, 1'b0);
    drive_beat(-1, 5, 1'b0, 1'b0, 1'b1);
    get_result("restart", 0);

    // headroom boundary: 256 terms fit, 257 flag overflow
    expect_result(24'hFE0100, 1'b0);
    for (int i = 0; i < 256; i++) drive_beat(255, 255, 1'b0, i == 0, i == 255);
    get_result("ovf256", 0);
    expect_result(24'hFEFF01, 1'b1);
    for (int i = 0; i < 257; i++) drive_beat(255, 255, 1'b0, i == 0, i == 256);
    get_result("ovf257", 0);
    expect_result(24'd1, 1'b0);
    drive_beat(1, 1, 1'b0, 1'b1, 1'b1);
    get_result("ovf_clear", 0);

    // reset mid-batch
    drive_beat(9, 9, 1'b0, 1'b1, 1'b0);
    drive_beat(8, 8, 1'b0, 1'b0, 1'b0);
    drive_beat(7, 7, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_result", result, '0);
    check("midrst_overflow", overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_result", out_valid, 1'b0);
    end
    expect_result(24'd63, 1'b0);
    drive_beat(7, 9, 1'b0, 1'b0, 1'b1);
    get_result("post_rst", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
